sobel_frame_ctrl: RTL and testbench
===================================

Name: sobel_frame_ctrl

Overview:
Per-frame sequencer for the HLS Sobel RGB green-outline core.
- Drives the core's ap_start / ap_done / ap_idle / ap_ready handshake.
- Checks output AXI-stream framing (line length, line count) against the configured geometry.
- Runs a no-progress watchdog, qualified by the core's deadlock-monitor `block` output.
- On stall, issues a bounded core soft reset and recovers to idle.
- Sits between the control/status register block and the accelerator instance.

Parameters:
IMG_W, 640, active pixels per line (beats per output line)
IMG_H, 480, lines per frame
WDOG_CYCLES, 65536, consecutive cycles with no output beat in RUN/DRAIN before stall is declared
BLOCK_CYCLES, 256, consecutive cycles of block_in high before stall is declared
RST_CYCLES, 16, core soft-reset pulse length in cycles

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; when high, frames are launched back to back
single_shot  in  1  one-cycle pulse; launches exactly one frame when idle
ap_start  out  1  core start
ap_done  in  1  core done pulse
ap_idle  in  1  core idle
ap_ready  in  1  core ready (start accepted)
out_tvalid  in  1  core output stream tap
out_tready  in  1  core output stream tap
out_tlast  in  1  end-of-line marker on output stream
block_in  in  1  deadlock monitor block flag
core_rst  out  1  active-high soft reset to core
busy  out  1  high in any state except IDLE
frame_count  out  16  completed good frames, wraps at 0xFFFF to 0
err_short  out  1  sticky: tlast before column IMG_W-1
err_long  out  1  sticky: column IMG_W-1 passed without tlast, or beats after last line
err_stall  out  1  sticky: watchdog or block timeout fired
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset values: all outputs 0; state = IDLE.
- Beat = out_tvalid & out_tready. Column counter col and line counter line advance on beats only.
- Sticky errors clear only on reset or when a new frame launches from IDLE.
- FSM states: IDLE=0, START=1, RUN=2, DRAIN=3, RECOVER=4.
- IDLE:
  - If (enable | single_shot) & ap_idle: go to START next cycle; clear col, line, watchdogs and sticky errors.
  - single_shot while not IDLE is ignored.
- START:
  - ap_start=1 (registered) until the cycle ap_ready=1 is sampled.
  - ap_start drops the cycle after ap_ready; go to RUN.
  - If the watchdog expires before ap_ready: go to RECOVER.
- RUN, per beat:
  - tlast & col<IMG_W-1: set err_short; col=0; line+1.
  - tlast & col==IMG_W-1: col=0; line+1.
  - !tlast & col==IMG_W-1: set err_long; col=0; line+1.
  - Otherwise col+1.
  - When line reaches IMG_H: go to DRAIN.
  - ap_done during RUN: go to DRAIN immediately; the frame counts as bad.
- DRAIN:
  - Wait for ap_done; ap_done may be seen already in RUN or on the same cycle as the last beat — never missed.
  - Any further beat sets err_long.
  - On ap_done: if no error this frame, frame_count+1.
  - Then: if enable, go to START, else go to IDLE.
- Watchdogs, active in START/RUN/DRAIN:
  - wd counts cycles without a beat; cleared on a beat.
  - bc counts consecutive cycles with block_in=1; cleared when block_in=0.
  - wd==WDOG_CYCLES-1 or bc==BLOCK_CYCLES-1: set err_stall; go to RECOVER.
  - Counters saturate; never wrap.
- RECOVER:
  - core_rst=1 for exactly RST_CYCLES cycles; ap_start=0.
  - Then wait for ap_idle; then go to IDLE.
  - enable does not auto-restart from RECOVER. Firmware must re-pulse single_shot, or enable is sampled again in IDLE.
- Simultaneous events:
  - Stall expiry on the same cycle as ap_done in DRAIN: ap_done wins; frame completes; err_stall stays 0.
- Reset mid-frame: all state cleared next cycle; core_rst is not asserted by this reset, because the core shares the reset.
- Latency: ap_start rises 2 cycles after single_shot, with ap_idle=1.

Decomposition:
- Shared package sobel_ctrl_pkg holds:
  - FSM state encoding constants.
  - Counter width function clog2.
  - Error bit positions {stall=2, long=1, short=0}, for the status register.
- Natural sub-module: sobel_stream_checker (col/line counters, framing errors, beat detection). The FSM and watchdogs stay in the top.

Test Plan:
1. IMG_W=4, IMG_H=2; single_shot; core returns ap_ready at +1; 8 beats, tlast on beats 4 and 8; ap_done at +2 -> frame_count=1, no errors, state IDLE, busy=0.
2. Same geometry, tlast on beat 3 -> err_short=1, frame_count stays 0; next single_shot clears err_short.
3. block_in held high with BLOCK_CYCLES=8 in RUN -> err_stall=1 after 8 cycles; core_rst high exactly RST_CYCLES=16 cycles; IDLE after ap_idle.
4. enable=1 for 3 frames -> frame_count=3; ap_start re-asserted directly from DRAIN; deassert enable mid-frame 3 -> returns to IDLE after frame 3.
5. ap_done on the same cycle as the final beat and as watchdog expiry -> frame counted; err_stall=0.
6. reset asserted in RUN after 5 beats -> next cycle all outputs 0, state_dbg=0; subsequent single_shot runs a clean frame.

Source files
------------

// File: rtl/sobel_ctrl_pkg.sv
// Shared definitions for the Sobel frame sequencer: state encoding, error bit
// positions for the status register, and a width helper.
package sobel_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StRun     = 3'd2,
    StDrain   = 3'd3,
    StRecover = 3'd4
  } ctrl_state_e;

  localparam int unsigned ErrBitShort = 0;
  localparam int unsigned ErrBitLong  = 1;
  localparam int unsigned ErrBitStall = 2;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Handshake and stream-tap signals between the frame sequencer (master) and
// the HLS Sobel core (slave).
interface sobel_frame_ctrl_if;
  logic ap_start;
  logic ap_done;
  logic ap_idle;
  logic ap_ready;
  logic out_tvalid;
  logic out_tready;
  logic out_tlast;
  logic block_in;
  logic core_rst;

  modport master (
    output ap_start, core_rst,
    input  ap_done, ap_idle, ap_ready, out_tvalid, out_tready, out_tlast, block_in
  );

  modport slave (
    input  ap_start, core_rst,
    output ap_done, ap_idle, ap_ready, out_tvalid, out_tready, out_tlast, block_in
  );
endinterface

// File: rtl/sobel_stream_checker.sv
// Output-stream framing checker: counts columns and lines on beats and flags
// short lines, long lines and beats past the end of the frame.
module sobel_stream_checker
  import sobel_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_sticky,
  input  logic clear_frame,
  input  logic run,
  input  logic drain,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  output logic beat,
  output logic frame_end,
  output logic err_now,
  output logic err_short,
  output logic err_long,
  output logic frame_err
);

  localparam int unsigned ColW = clog2(IMG_W);
  localparam int unsigned LineW = clog2(IMG_H + 1);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [LineW-1:0] LineLast = LineW'(IMG_H - 1);

  logic [ColW-1:0]  col_q, col_d;
  logic [LineW-1:0] line_q, line_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic             frame_err_q, frame_err_d;
  logic             at_last_col, line_end, short_now, long_now;

  always_comb begin
    beat        = tvalid & tready;
    at_last_col = (col_q == ColLast);
    line_end    = tlast | at_last_col;
    short_now   = run & beat & tlast & ~at_last_col;
    // Missing tlast at the last column, or any beat once the frame is over.
    long_now    = (run & beat & ~tlast & at_last_col) | (drain & beat);
    err_now     = short_now | long_now;
    frame_end   = run & beat & line_end & (line_q == LineLast);

    col_d  = col_q;
    line_d = line_q;
    if (clear_frame) begin
      col_d  = '0;
      line_d = '0;
    end else if (run & beat) begin
      if (line_end) begin
        col_d  = '0;
        line_d = line_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    err_short_d = clear_sticky ? 1'b0 : (err_short_q | short_now);
    err_long_d  = clear_sticky ? 1'b0 : (err_long_q | long_now);
    frame_err_d = clear_frame ? 1'b0 : (frame_err_q | err_now);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q       <= '0;
      line_q      <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      line_q      <= line_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Per-frame sequencer for the HLS Sobel core: start/done handshake, framing
// checks, no-progress and block watchdogs, and soft-reset recovery.
module sobel_frame_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W        = 640,
  parameter int unsigned IMG_H        = 480,
  parameter int unsigned WDOG_CYCLES  = 65536,
  parameter int unsigned BLOCK_CYCLES = 256,
  parameter int unsigned RST_CYCLES   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                single_shot,
  sobel_frame_ctrl_if.master  core,
  output logic                busy,
  output logic [15:0]         frame_count,
  output logic                err_short,
  output logic                err_long,
  output logic                err_stall,
  output logic [2:0]          state_dbg
);

  localparam int unsigned WdW = clog2(WDOG_CYCLES);
  localparam int unsigned BcW = clog2(BLOCK_CYCLES);
  localparam int unsigned RcW = clog2(RST_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(WDOG_CYCLES - 1);
  localparam logic [BcW-1:0] BcLast = BcW'(BLOCK_CYCLES - 1);
  localparam logic [RcW-1:0] RcDone = RcW'(RST_CYCLES);

  ctrl_state_e    state_q, state_d;
  logic           ap_start_q, ap_start_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic [BcW-1:0] bc_q, bc_d;
  logic [RcW-1:0] rc_q, rc_d;
  logic           done_seen_q, done_seen_d;
  logic           bad_q, bad_d;
  logic           err_stall_q, err_stall_d;
  logic [15:0]    frame_count_q, frame_count_d;

  logic active, stall, idle_launch, drain_done, launch, accepted;
  logic beat, frame_end, err_now, frame_err;

  sobel_stream_checker #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_checker (
    .clock        (clock),
    .reset        (reset),
    .clear_sticky (idle_launch),
    .clear_frame  (launch),
    .run          (state_q == StRun),
    .drain        (state_q == StDrain),
    .tvalid       (core.out_tvalid),
    .tready       (core.out_tready),
    .tlast        (core.out_tlast),
    .beat         (beat),
    .frame_end    (frame_end),
    .err_now      (err_now),
    .err_short    (err_short),
    .err_long     (err_long),
    .frame_err    (frame_err)
  );

  always_comb begin
    active      = (state_q == StStart) || (state_q == StRun) || (state_q == StDrain);
    stall       = active && ((wd_q == WdLast) || (bc_q == BcLast));
    idle_launch = (state_q == StIdle) && (enable || single_shot) && core.ap_idle;
    drain_done  = (state_q == StDrain) && (core.ap_done || done_seen_q);
    launch      = idle_launch || (drain_done && enable);
    accepted    = (state_q == StStart) && ap_start_q && core.ap_ready;

    state_d       = state_q;
    done_seen_d   = done_seen_q;
    bad_d         = bad_q;
    err_stall_d   = err_stall_q;
    frame_count_d = frame_count_q;

    if (launch) begin
      done_seen_d = 1'b0;
      bad_d       = 1'b0;
    end
    if (idle_launch) err_stall_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (idle_launch) state_d = StStart;
      end
      StStart: begin
        if (accepted) begin
          state_d = StRun;
        end else if (stall) begin
          state_d     = StRecover;
          err_stall_d = 1'b1;
        end
      end
      StRun: begin
        // Done together with the final beat is a normal completion and beats a stall.
        if (core.ap_done && frame_end) begin
          state_d     = StDrain;
          done_seen_d = 1'b1;
        end else if (stall) begin
          state_d     = StRecover;
          err_stall_d = 1'b1;
        end else if (core.ap_done) begin
          state_d     = StDrain;
          done_seen_d = 1'b1;
          bad_d       = 1'b1;
        end else if (frame_end) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_done) begin
          if (!(bad_q || frame_err || err_now)) frame_count_d = frame_count_q + 16'd1;
          state_d = enable ? StStart : StIdle;
        end else if (stall) begin
          state_d     = StRecover;
          err_stall_d = 1'b1;
        end
      end
      StRecover: begin
        if ((rc_q == RcDone) && core.ap_idle) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Registered start: rises one cycle after entering START, drops after ap_ready.
    ap_start_d = (state_q == StStart) && (state_d == StStart);

    if (!active || launch || beat) wd_d = '0;
    else if (wd_q != WdLast)       wd_d = wd_q + 1'b1;
    else                           wd_d = wd_q;

    if (!active || launch || !core.block_in) bc_d = '0;
    else if (bc_q != BcLast)                 bc_d = bc_q + 1'b1;
    else                                     bc_d = bc_q;

    if (state_q != StRecover) rc_d = '0;
    else if (rc_q != RcDone)  rc_d = rc_q + 1'b1;
    else                      rc_d = rc_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      ap_start_q    <= 1'b0;
      wd_q          <= '0;
      bc_q          <= '0;
      rc_q          <= '0;
      done_seen_q   <= 1'b0;
      bad_q         <= 1'b0;
      err_stall_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ap_start_q    <= ap_start_d;
      wd_q          <= wd_d;
      bc_q          <= bc_d;
      rc_q          <= rc_d;
      done_seen_q   <= done_seen_d;
      bad_q         <= bad_d;
      err_stall_q   <= err_stall_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign core.ap_start = ap_start_q;
  assign core.core_rst = (state_q == StRecover) && (rc_q != RcDone);
  assign busy          = (state_q != StIdle);
  assign frame_count   = frame_count_q;
  assign err_stall     = err_stall_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with a 4x2 frame and short timeouts;
// the bench plays the role of the Sobel core.
module tb_sobel_frame_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned WD = 20;
  localparam int unsigned BC = 8;
  localparam int unsigned RC = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        single_shot = 1'b0;
  logic        busy;
  logic [15:0] frame_count;
  logic        err_short, err_long, err_stall;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  sobel_frame_ctrl_if core_if ();

  sobel_frame_ctrl #(
    .IMG_W        (W),
    .IMG_H        (H),
    .WDOG_CYCLES  (WD),
    .BLOCK_CYCLES (BC),
    .RST_CYCLES   (RC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .single_shot (single_shot),
    .core        (core_if),
    .busy        (busy),
    .frame_count (frame_count),
    .err_short   (err_short),
    .err_long    (err_long),
    .err_stall   (err_stall),
    .state_dbg   (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic last);
    core_if.out_tvalid = 1'b1;
    core_if.out_tready = 1'b1;
    core_if.out_tlast  = last;
    step();
    core_if.out_tvalid = 1'b0;
    core_if.out_tlast  = 1'b0;
  endtask

  task automatic clean_beats();
    for (int i = 0; i < 8; i++) beat(i % 4 == 3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // single_shot launch plus core acceptance; leaves the DUT in RUN.
  task automatic launch_ss();
    single_shot = 1'b1;
    step();
    single_shot = 1'b0;
    step();
    check("launch_ap_start", core_if.ap_start, 1);
    core_if.ap_ready = 1'b1;
    core_if.ap_idle  = 1'b0;
    step();
    core_if.ap_ready = 1'b0;
  endtask

  task automatic finish_done();
    core_if.ap_done = 1'b1;
    core_if.ap_idle = 1'b1;
    step();
    core_if.ap_done = 1'b0;
  endtask

  task automatic core_frame(input logic drop_enable);
    int n;
    n = 0;
    while (core_if.ap_start !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("frame_ap_start_seen", core_if.ap_start, 1);
    core_if.ap_ready = 1'b1;
    core_if.ap_idle  = 1'b0;
    step();
    core_if.ap_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(i % 4 == 3);
      if (drop_enable && i == 3) enable = 1'b0;
    end
    step();
    finish_done();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    core_if.ap_done    = 1'b0;
    core_if.ap_idle    = 1'b1;
    core_if.ap_ready   = 1'b0;
    core_if.out_tvalid = 1'b0;
    core_if.out_tready = 1'b0;
    core_if.out_tlast  = 1'b0;
    core_if.block_in   = 1'b0;

    // Reset state
    idle(2);
    reset = 1'b0;
    check("rst_state", state_dbg, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_errs", {err_stall, err_long, err_short}, 0);
    check("rst_ap_start", core_if.ap_start, 0);
    check("rst_core_rst", core_if.core_rst, 0);

    // 1: clean single-shot frame, ap_start latency of 2
    single_shot = 1'b1;
    step();
    single_shot = 1'b0;
    check("t1_state_start", state_dbg, 1);
    check("t1_ap_start_lo", core_if.ap_start, 0);
    step();
    check("t1_ap_start_hi", core_if.ap_start, 1);
    core_if.ap_ready = 1'b1;
    core_if.ap_idle  = 1'b0;
    step();
    core_if.ap_ready = 1'b0;
    check("t1_state_run", state_dbg, 2);
    check("t1_ap_start_drop", core_if.ap_start, 0);
    clean_beats();
    check("t1_state_drain", state_dbg, 3);
    step();
    check("t1_still_drain", state_dbg, 3);
    finish_done();
    check("t1_frame_count", frame_count, 1);
    check("t1_state_idle", state_dbg, 0);
    check("t1_busy", busy, 0);
    check("t1_errs", {err_stall, err_long, err_short}, 0);

    // 2: short line
    launch_ss();
    beat(1'b0);
    beat(1'b0);
    beat(1'b1);
    check("t2_err_short", err_short, 1);
    check("t2_state_run", state_dbg, 2);
    for (int i = 0; i < 4; i++) beat(i == 3);
    check("t2_state_drain", state_dbg, 3);
    step();
    finish_done();
    check("t2_frame_count", frame_count, 1);
    check("t2_sticky", err_short, 1);

    // 3: block timeout and recovery
    launch_ss();
    check("t3_err_short_cleared", err_short, 0);
    core_if.block_in = 1'b1;
    idle(BC - 1);
    check("t3_no_early_stall", state_dbg, 2);
    step();
    core_if.block_in = 1'b0;
    check("t3_state_recover", state_dbg, 4);
    check("t3_err_stall", err_stall, 1);
    check("t3_ap_start", core_if.ap_start, 0);
    n = 0;
    while (core_if.core_rst === 1'b1 && n < 100) begin
      n++;
      step();
    end
    check("t3_core_rst_len", n, RC);
    step();
    check("t3_wait_idle", state_dbg, 4);
    core_if.ap_idle = 1'b1;
    step();
    check("t3_state_idle", state_dbg, 0);
    check("t3_stall_sticky", err_stall, 1);

    // 4: back-to-back frames under enable
    enable = 1'b1;
    step();
    check("t4_state_start", state_dbg, 1);
    check("t4_err_stall_cleared", err_stall, 0);
    core_frame(1'b0);
    check("t4_restart_from_drain", state_dbg, 1);
    check("t4_count_a", frame_count, 2);
    core_frame(1'b0);
    check("t4_count_b", frame_count, 3);
    core_frame(1'b1);
    check("t4_count_c", frame_count, 4);
    check("t4_state_idle", state_dbg, 0);
    check("t4_busy", busy, 0);

    // 5a: final beat, ap_done and watchdog expiry on one cycle
    launch_ss();
    for (int i = 0; i < 7; i++) beat(i == 3);
    idle(WD - 1);
    check("t5a_no_early_stall", state_dbg, 2);
    core_if.ap_done = 1'b1;
    core_if.ap_idle = 1'b1;
    beat(1'b1);
    core_if.ap_done = 1'b0;
    check("t5a_state_drain", state_dbg, 3);
    check("t5a_err_stall", err_stall, 0);
    step();
    check("t5a_state_idle", state_dbg, 0);
    check("t5a_frame_count", frame_count, 5);

    // 5b: ap_done and watchdog expiry together in DRAIN
    launch_ss();
    clean_beats();
    idle(WD - 1);
    check("t5b_still_drain", state_dbg, 3);
    finish_done();
    check("t5b_state_idle", state_dbg, 0);
    check("t5b_err_stall", err_stall, 0);
    check("t5b_frame_count", frame_count, 6);

    // 6: reset mid-frame
    launch_ss();
    for (int i = 0; i < 5; i++) beat(i % 4 == 3);
    reset = 1'b1;
    core_if.ap_idle = 1'b1;
    step();
    reset = 1'b0;
    check("t6_state", state_dbg, 0);
    check("t6_busy", busy, 0);
    check("t6_frame_count", frame_count, 0);
    check("t6_ap_start", core_if.ap_start, 0);
    check("t6_core_rst", core_if.core_rst, 0);
    launch_ss();
    clean_beats();
    step();
    finish_done();
    check("t6_clean_count", frame_count, 1);
    check("t6_clean_errs", {err_stall, err_long, err_short}, 0);

    // 7a: missing tlast -> long line
    launch_ss();
    for (int i = 0; i < 4; i++) beat(1'b0);
    check("t7a_err_long", err_long, 1);
    check("t7a_err_short", err_short, 0);
    for (int i = 0; i < 4; i++) beat(1'b0);
    check("t7a_state_drain", state_dbg, 3);
    step();
    finish_done();
    check("t7a_frame_count", frame_count, 1);

    // 7b: extra beat after the last line
    launch_ss();
    check("t7b_err_long_cleared", err_long, 0);
    clean_beats();
    beat(1'b0);
    check("t7b_err_long", err_long, 1);
    finish_done();
    check("t7b_frame_count", frame_count, 1);
    check("t7b_state_idle", state_dbg, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
